// File: rtl/dma_psdpram_seg_rd.sv
// Segmented simple-dual-port DMA packet RAM. Each segment is an independent
// bank with its own byte-enable write port and its own back-pressured read pipeline.

module dma_psdpram_seg_rd_seg #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int PIPELINE   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_done,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic [PIPELINE-1:0]                 vld_pipe;
  logic [PIPELINE-1:0][DATA_WIDTH-1:0] data_pipe;
  logic [PIPELINE-1:0]                 adv;
  logic                                wr_en;

  assign wr_en = wr_valid & ~rst;

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_done <= 1'b0;
    else     wr_done <= wr_en;
  end

  // A stage may advance when the output is being taken or any stage from it
  // to the output is empty; written flat so no bit depends on another.
  always_comb begin
    logic full;
    adv  = '0;
    full = 1'b1;
    for (int k = 0; k < PIPELINE; k++) begin
      full = 1'b1;
      for (int j = k; j < PIPELINE; j++) full = full & vld_pipe[j];
      adv[k] = rd_data_ready | ~full;
    end
  end

  assign rd_ready = adv[0] & ~rst;

  // Stage 0 is the registered RAM output; the RAM is only read when it loads,
  // and a stage's data only changes when a valid word moves into it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      if (adv[0]) begin
        vld_pipe[0] <= rd_valid;
        if (rd_valid) data_pipe[0] <= mem[rd_addr];
      end
      for (int k = 1; k < PIPELINE; k++) begin
        if (adv[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) data_pipe[k] <= data_pipe[k-1];
        end
      end
    end
  end

  assign rd_data       = data_pipe[PIPELINE-1];
  assign rd_data_valid = vld_pipe[PIPELINE-1];

endmodule

module dma_psdpram_seg_rd #(
  parameter int SEG_COUNT      = 8,
  parameter int SEG_DATA_WIDTH = 128,
  parameter int SEG_ADDR_WIDTH = 12,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH/8,
  parameter int PIPELINE       = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   wr_cmd_be,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] wr_cmd_addr,
  input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] wr_cmd_data,
  input  logic [SEG_COUNT-1:0]                wr_cmd_valid,
  output logic [SEG_COUNT-1:0]                wr_cmd_ready,
  output logic [SEG_COUNT-1:0]                wr_done,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] rd_cmd_addr,
  input  logic [SEG_COUNT-1:0]                rd_cmd_valid,
  output logic [SEG_COUNT-1:0]                rd_cmd_ready,
  output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data,
  output logic [SEG_COUNT-1:0]                rd_resp_valid,
  input  logic [SEG_COUNT-1:0]                rd_resp_ready
);

  // Writes never stall; the port only refuses while reset is held.
  assign wr_cmd_ready = {SEG_COUNT{~rst}};

  for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
    dma_psdpram_seg_rd_seg #(
      .DATA_WIDTH (SEG_DATA_WIDTH),
      .ADDR_WIDTH (SEG_ADDR_WIDTH),
      .BE_WIDTH   (SEG_BE_WIDTH),
      .PIPELINE   (PIPELINE)
    ) u_seg (
      .clk           (clk),
      .rst           (rst),
      .wr_be         (wr_cmd_be[n*SEG_BE_WIDTH +: SEG_BE_WIDTH]),
      .wr_addr       (wr_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
      .wr_data       (wr_cmd_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
      .wr_valid      (wr_cmd_valid[n]),
      .wr_done       (wr_done[n]),
      .rd_addr       (rd_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
      .rd_valid      (rd_cmd_valid[n]),
      .rd_ready      (rd_cmd_ready[n]),
      .rd_data       (rd_resp_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
      .rd_data_valid (rd_resp_valid[n]),
      .rd_data_ready (rd_resp_ready[n])
    );
  end

endmodule

// File: tb/tb_dma_psdpram_seg_rd.sv
// Bench for dma_psdpram_seg_rd: directed scenarios plus random traffic, all
// checked against a per-segment memory array and in-order response queues.

module tb_dma_psdpram_seg_rd;
  localparam int SC = 8;
  localparam int DW = 128;
  localparam int AW = 12;
  localparam int BE = DW/8;
  localparam int P  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [SC-1:0][BE-1:0] wr_cmd_be    = '0;
  logic [SC-1:0][AW-1:0] wr_cmd_addr  = '0;
  logic [SC-1:0][DW-1:0] wr_cmd_data  = '0;
  logic [SC-1:0]         wr_cmd_valid = '0;
  logic [SC-1:0]         wr_cmd_ready;
  logic [SC-1:0]         wr_done;
  logic [SC-1:0][AW-1:0] rd_cmd_addr  = '0;
  logic [SC-1:0]         rd_cmd_valid = '0;
  logic [SC-1:0]         rd_cmd_ready;
  logic [SC-1:0][DW-1:0] rd_resp_data;
  logic [SC-1:0]         rd_resp_valid;
  logic [SC-1:0]         rd_resp_ready = '1;

  dma_psdpram_seg_rd #(
    .SEG_COUNT(SC), .SEG_DATA_WIDTH(DW), .SEG_ADDR_WIDTH(AW), .PIPELINE(P)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_cmd_be(wr_cmd_be), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_data(wr_cmd_data),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_done(wr_done),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_resp_data(rd_resp_data), .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [SC][1<<AW];
  logic [DW-1:0] exp_q [SC][$];
  logic [SC-1:0] prev_stall = '0;
  logic [SC-1:0][DW-1:0] prev_data;

  // Scoreboard: sampled mid-cycle, so the handshakes seen here are the ones the
  // next edge completes. Reads are queued before writes are applied (read-first).
  always @(negedge clk) begin
    logic [DW-1:0] expw;
    if (rst) begin
      for (int s = 0; s < SC; s++) exp_q[s].delete();
      prev_stall = '0;
    end else begin
      for (int s = 0; s < SC; s++) begin
        if (prev_stall[s]) begin
          checks++;
          if (rd_resp_valid[s] !== 1'b1 || rd_resp_data[s] !== prev_data[s]) begin
            errors++;
            $display("FAIL stall_stable seg%0d valid=%b data=%h want valid=1 data=%h",
                     s, rd_resp_valid[s], rd_resp_data[s], prev_data[s]);
          end
        end
        prev_stall[s] = rd_resp_valid[s] & ~rd_resp_ready[s];
        prev_data[s]  = rd_resp_data[s];
        if (rd_resp_valid[s] && rd_resp_ready[s]) begin
          checks++;
          if (exp_q[s].size() == 0) begin
            errors++;
            $display("FAIL sb_extra seg%0d got %h want no response", s, rd_resp_data[s]);
          end else begin
            expw = exp_q[s].pop_front();
            if (rd_resp_data[s] !== expw) begin
              errors++;
              $display("FAIL sb_data seg%0d got %h want %h", s, rd_resp_data[s], expw);
            end
          end
        end
        if (rd_cmd_valid[s] && rd_cmd_ready[s]) exp_q[s].push_back(model[s][rd_cmd_addr[s]]);
        if (wr_cmd_valid[s] && wr_cmd_ready[s])
          for (int b = 0; b < BE; b++)
            if (wr_cmd_be[s][b]) model[s][wr_cmd_addr[s]][b*8 +: 8] = wr_cmd_data[s][b*8 +: 8];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_write(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BE-1:0] be);
    wr_cmd_valid[s] = 1'b1; wr_cmd_addr[s] = a; wr_cmd_data[s] = d; wr_cmd_be[s] = be;
    tick();
    wr_cmd_valid[s] = 1'b0;
  endtask

  task automatic wait_resp(input int s, output logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (rd_resp_valid[s] && rd_resp_ready[s]) begin
        d = rd_resp_data[s];
        ok = 1'b1;
      end
      tick();
    end
  endtask

  task automatic read_one(input int s, input logic [AW-1:0] a, output logic [DW-1:0] d,
                          output bit ok);
    rd_cmd_valid[s] = 1'b1; rd_cmd_addr[s] = a;
    #1;
    for (int i = 0; i < 12 && !rd_cmd_ready[s]; i++) tick();
    tick();
    rd_cmd_valid[s] = 1'b0;
    wait_resp(s, d, ok);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (rd_resp_valid !== '0 || wr_done !== '0 || rd_resp_data !== '0 || wr_cmd_ready !== '0) begin
      errors++;
      $display("FAIL reset_state rvalid=%h wdone=%h wready=%h want all 0",
               rd_resp_valid, wr_done, wr_cmd_ready);
    end
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (wr_cmd_ready !== '1 || rd_cmd_ready !== '1) begin
      errors++;
      $display("FAIL reset_release wready=%h rready=%h want ff ff", wr_cmd_ready, rd_cmd_ready);
    end
  endtask

  task automatic test_basic_read();
    logic [DW-1:0] d = 128'h00112233445566778899AABBCCDDEEFF;
    rd_resp_ready = '1;
    do_write(0, 12'h005, d, '1);
    checks++;
    if (wr_done !== 8'h01) begin
      errors++; $display("FAIL wr_done_pulse got %h want 01", wr_done);
    end
    tick();
    checks++;
    if (wr_done !== 8'h00) begin
      errors++; $display("FAIL wr_done_single got %h want 00", wr_done);
    end
    rd_cmd_valid[0] = 1'b1; rd_cmd_addr[0] = 12'h005;
    tick();
    rd_cmd_valid[0] = 1'b0;
    checks++;
    if (rd_resp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL basic_early got valid=%b want 0", rd_resp_valid[0]);
    end
    tick();
    checks++;
    if (rd_resp_valid[0] !== 1'b1 || rd_resp_data[0] !== d) begin
      errors++;
      $display("FAIL basic_latency valid=%b data=%h want 1 %h", rd_resp_valid[0], rd_resp_data[0], d);
    end
    tick();
    checks++;
    if (rd_resp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL basic_single got valid=%b want 0", rd_resp_valid[0]);
    end
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] d;
    logic [DW-1:0] want = {{15{8'hAA}}, 8'h55};
    bit ok;
    do_write(3, 12'hFFF, {16{8'hAA}}, '1);
    do_write(3, 12'hFFF, 128'h55, 16'h0001);
    read_one(3, 12'hFFF, d, ok);
    checks++;
    if (!ok || d !== want) begin
      errors++; $display("FAIL byte_enable ok=%0b got %h want %h", ok, d, want);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w [6];
    logic [DW-1:0] d0;
    int idx = 0;
    bit stable = 1'b1;
    bit acc;
    for (int i = 0; i < 6; i++) begin
      w[i] = rnd128();
      do_write(1, AW'(i), w[i], '1);
    end
    rd_resp_ready[1] = 1'b0;
    rd_cmd_valid[1]  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd_cmd_addr[1] = AW'(idx);
      #1;
      acc = rd_cmd_ready[1];
      tick();
      if (acc) idx++;
    end
    rd_cmd_valid[1] = 1'b0;
    checks++;
    if (idx != 2 || rd_cmd_ready[1] !== 1'b0) begin
      errors++; $display("FAIL bp_fill accepted=%0d ready=%b want 2 0", idx, rd_cmd_ready[1]);
    end
    d0 = rd_resp_data[1];
    for (int i = 0; i < 10; i++) begin
      if (rd_resp_valid[1] !== 1'b1 || rd_resp_data[1] !== d0) stable = 1'b0;
      tick();
    end
    checks++;
    if (!stable || d0 !== w[0]) begin
      errors++; $display("FAIL bp_hold stable=%0b data=%h want 1 %h", stable, d0, w[0]);
    end
    rd_resp_ready[1] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      rd_cmd_valid[1] = (idx < 6);
      rd_cmd_addr[1]  = AW'(idx);
      #1;
      acc = rd_cmd_valid[1] & rd_cmd_ready[1];
      checks++;
      if (rd_resp_valid[1] !== 1'b1 || rd_resp_data[1] !== w[j]) begin
        errors++;
        $display("FAIL bp_drain%0d valid=%b data=%h want 1 %h", j, rd_resp_valid[1], rd_resp_data[1], w[j]);
      end
      tick();
      if (acc) idx++;
    end
    rd_cmd_valid[1] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_independence();
    int acc_cnt [SC];
    int rsp_cnt [SC];
    int ptr [SC];
    logic [SC-1:0] acc, rsp;
    for (int a = 0; a < 8; a++) begin
      for (int s = 0; s < SC; s++) begin
        wr_cmd_addr[s] = AW'(a); wr_cmd_data[s] = rnd128(); wr_cmd_be[s] = '1;
      end
      wr_cmd_valid = '1;
      tick();
    end
    wr_cmd_valid = '0;
    for (int s = 0; s < SC; s++) begin acc_cnt[s] = 0; rsp_cnt[s] = 0; ptr[s] = 0; end
    rd_resp_ready = 8'hFB;
    rd_cmd_valid  = '1;
    for (int j = 0; j < 12; j++) begin
      for (int s = 0; s < SC; s++) rd_cmd_addr[s] = AW'(ptr[s] % 8);
      #1;
      acc = rd_cmd_ready;
      rsp = rd_resp_valid & rd_resp_ready;
      tick();
      for (int s = 0; s < SC; s++) begin
        if (acc[s]) begin acc_cnt[s]++; ptr[s]++; end
        if (rsp[s]) rsp_cnt[s]++;
      end
    end
    rd_cmd_valid = '0;
    for (int s = 0; s < SC; s++) begin
      checks++;
      if (acc_cnt[s] != (s == 2 ? 2 : 12) || rsp_cnt[s] != (s == 2 ? 0 : 10)) begin
        errors++;
        $display("FAIL indep_rate seg%0d acc=%0d rsp=%0d want %0d %0d", s, acc_cnt[s], rsp_cnt[s],
                 (s == 2 ? 2 : 12), (s == 2 ? 0 : 10));
      end
    end
    rd_resp_ready = '1;
    repeat (5) tick();
    for (int s = 0; s < SC; s++) begin
      checks++;
      if (exp_q[s].size() != 0 || rd_resp_valid[s] !== 1'b0) begin
        errors++;
        $display("FAIL indep_drain seg%0d pending=%0d valid=%b want 0 0", s, exp_q[s].size(), rd_resp_valid[s]);
      end
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] d;
    bit ok;
    do_write(4, 12'h010, 128'h1, '1);
    wr_cmd_valid[4] = 1'b1; wr_cmd_addr[4] = 12'h010; wr_cmd_data[4] = 128'h2; wr_cmd_be[4] = '1;
    rd_cmd_valid[4] = 1'b1; rd_cmd_addr[4] = 12'h010;
    tick();
    wr_cmd_valid[4] = 1'b0; rd_cmd_valid[4] = 1'b0;
    wait_resp(4, d, ok);
    checks++;
    if (!ok || d !== 128'h1) begin
      errors++; $display("FAIL collision_old ok=%0b got %h want 1", ok, d);
    end
    read_one(4, 12'h010, d, ok);
    checks++;
    if (!ok || d !== 128'h2) begin
      errors++; $display("FAIL collision_new ok=%0b got %h want 2", ok, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w0 = rnd128();
    logic [DW-1:0] w1 = rnd128();
    logic [DW-1:0] d;
    bit ok;
    do_write(6, 12'h020, w0, '1);
    do_write(6, 12'h021, w1, '1);
    rd_resp_ready = '1;
    rd_cmd_valid[6] = 1'b1; rd_cmd_addr[6] = 12'h020;
    tick();
    rd_cmd_addr[6] = 12'h021;
    tick();
    rd_cmd_valid[6] = 1'b0;
    checks++;
    if (rd_resp_valid[6] !== 1'b1) begin
      errors++; $display("FAIL rst_inflight got valid=%b want 1", rd_resp_valid[6]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rd_resp_valid !== '0 || wr_cmd_ready !== '0) begin
      errors++; $display("FAIL rst_async valid=%h wready=%h want 00 00", rd_resp_valid, wr_cmd_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (rd_resp_valid !== '0) begin
      errors++; $display("FAIL rst_flush valid=%h want 00", rd_resp_valid);
    end
    read_one(6, 12'h021, d, ok);
    checks++;
    if (!ok || d !== w1) begin
      errors++; $display("FAIL rst_preserve ok=%0b got %h want %h", ok, d, w1);
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 16; a++) begin
      for (int s = 0; s < SC; s++) begin
        wr_cmd_addr[s] = AW'(a); wr_cmd_data[s] = rnd128(); wr_cmd_be[s] = '1;
      end
      wr_cmd_valid = '1;
      tick();
    end
    wr_cmd_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < SC; s++) begin
        wr_cmd_valid[s]  = ($urandom_range(0, 2) == 0);
        wr_cmd_addr[s]   = AW'($urandom_range(0, 15));
        wr_cmd_data[s]   = rnd128();
        wr_cmd_be[s]     = BE'($urandom);
        rd_cmd_valid[s]  = $urandom_range(0, 1);
        rd_cmd_addr[s]   = AW'($urandom_range(0, 15));
        rd_resp_ready[s] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    wr_cmd_valid  = '0;
    rd_cmd_valid  = '0;
    rd_resp_ready = '1;
    repeat (6) tick();
    for (int s = 0; s < SC; s++) begin
      checks++;
      if (exp_q[s].size() != 0 || rd_resp_valid[s] !== 1'b0) begin
        errors++;
        $display("FAIL rand_drain seg%0d pending=%0d valid=%b want 0 0", s, exp_q[s].size(), rd_resp_valid[s]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_byte_enable();
    test_backpressure();
    test_independence();
    test_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
